// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALUOp and PCSrc codes. ALUControl imports the ALUOp codes from here as well.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_TRAP   = 4'd15
    } state_t;

    // Last state of every legal instruction; leaving it retires the instruction.
    function automatic logic is_retire(input state_t s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RWB) ||
               (s == S_IWB)   || (s == S_BRANCH) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: one state register plus a combinational
// output decoder; BRANCH PCWrite follows Zero, all strobes gated off during reset.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             Zero,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic [1:0]       ALUOp,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       PCSrc,
    output logic             Trap,
    output logic [CNT_W-1:0] InstrCount,
    output logic [3:0]       State
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (is_retire(r_state))
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        w_next = S_TRAP;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_IEXEC;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_TRAP;
                endcase
            end
            // Opcode is still held in the IR here, so it picks load vs store.
            S_MEMADR: w_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXEC:   w_next = S_RWB;
            S_IEXEC:  w_next = S_IWB;
            S_MEMWB, S_MEMWR, S_RWB, S_IWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_TRAP;
        endcase
    end

    always_comb begin
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        ALUOp    = ALUOP_ADD;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = PCSRC_PC4;
        Trap     = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
            end
            S_MEMADR, S_IEXEC: ALUSrc = 1'b1;
            S_MEMRD: MemRead = 1'b1;
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEMWR: MemWrite = 1'b1;
            S_EXEC:  ALUOp = ALUOP_FUNC;
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_IWB:   RegWrite = 1'b1;
            S_BRANCH: begin
                ALUOp   = ALUOP_SUB;
                PCSrc   = PCSRC_BRANCH;
                PCWrite = Zero;
            end
            S_JUMP: begin
                PCSrc   = PCSRC_JUMP;
                PCWrite = 1'b1;
            end
            S_TRAP:  Trap = 1'b1;
            default: ;
        endcase
        // Architectural side effects are suppressed while reset is held.
        if (reset) begin
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            Trap     = 1'b0;
        end
    end

    assign InstrCount = r_count;
    assign State      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues one expected record
// per cycle, a negedge monitor pops and compares against the DUT.
module tb_multicycle_control;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  Opcode;
    logic        Zero;
    logic        RegDst, ALUSrc, MemWrite, MemRead, MemToReg, RegWrite;
    logic [1:0]  ALUOp, PCSrc;
    logic        IRWrite, PCWrite, Trap;
    logic [31:0] InstrCount;
    logic [3:0]  State;

    logic        s_RegDst, s_ALUSrc, s_MemWrite, s_MemRead, s_MemToReg, s_RegWrite;
    logic [1:0]  s_ALUOp, s_PCSrc;
    logic        s_IRWrite, s_PCWrite, s_Trap;
    logic [2:0]  s_InstrCount;
    logic [3:0]  s_State;

    always #5 clock = ~clock;

    multicycle_control #(.CNT_W(32)) dut (
        .clock(clock), .reset(reset), .Opcode(Opcode), .Zero(Zero),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemRead(MemRead),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUOp(ALUOp), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .Trap(Trap), .InstrCount(InstrCount),
        .State(State)
    );

    // Narrow counter instance shares every input so its all-ones -> 0 wrap is reachable.
    multicycle_control #(.CNT_W(3)) dut_small (
        .clock(clock), .reset(reset), .Opcode(Opcode), .Zero(Zero),
        .RegDst(s_RegDst), .ALUSrc(s_ALUSrc), .MemWrite(s_MemWrite), .MemRead(s_MemRead),
        .MemToReg(s_MemToReg), .RegWrite(s_RegWrite), .ALUOp(s_ALUOp), .IRWrite(s_IRWrite),
        .PCWrite(s_PCWrite), .PCSrc(s_PCSrc), .Trap(s_Trap), .InstrCount(s_InstrCount),
        .State(s_State)
    );

    localparam logic [12:0] RST_MASK = 13'b0011010011001;

    typedef struct packed {
        logic [3:0]  st;
        logic [12:0] ctrl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_cnt  = 0;

    // {RegDst,ALUSrc,MemWrite,MemRead,MemToReg,RegWrite,ALUOp[2],IRWrite,PCWrite,PCSrc[2],Trap}
    function automatic logic [12:0] ctrl_of(input logic [3:0] st, input logic z);
        case (st)
            4'd0:    return 13'b0_0_0_1_0_0_00_1_1_00_0;
            4'd1:    return 13'b0_0_0_0_0_0_00_0_0_00_0;
            4'd2:    return 13'b0_1_0_0_0_0_00_0_0_00_0;
            4'd3:    return 13'b0_0_0_1_0_0_00_0_0_00_0;
            4'd4:    return 13'b0_0_0_0_1_1_00_0_0_00_0;
            4'd5:    return 13'b0_0_1_0_0_0_00_0_0_00_0;
            4'd6:    return 13'b0_0_0_0_0_0_10_0_0_00_0;
            4'd7:    return 13'b1_0_0_0_0_1_00_0_0_00_0;
            4'd8:    return z ? 13'b0_0_0_0_0_0_01_0_1_01_0 : 13'b0_0_0_0_0_0_01_0_0_01_0;
            4'd9:    return 13'b0_0_0_0_0_0_00_0_1_10_0;
            4'd10:   return 13'b0_1_0_0_0_0_00_0_0_00_0;
            4'd11:   return 13'b0_0_0_0_0_1_00_0_0_00_0;
            default: return 13'b0_0_0_0_0_0_00_0_0_00_1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("state", {28'd0, State}, {28'd0, e.st});
            chk("ctrl", {19'd0, RegDst, ALUSrc, MemWrite, MemRead, MemToReg, RegWrite,
                         ALUOp, IRWrite, PCWrite, PCSrc, Trap}, {19'd0, e.ctrl});
            chk("instr_count", InstrCount, e.cnt);
            chk("instr_count_w3", {29'd0, s_InstrCount}, {29'd0, e.cnt[2:0]});
            chk("rd_wr_excl", {31'd0, MemRead & MemWrite}, 32'd0);
        end
    end

    task automatic step(input logic rst, input logic [3:0] st, input logic [5:0] op, input logic z);
        exp_t e;
        reset  = rst;
        Opcode = op;
        Zero   = z;
        e.st   = st;
        e.ctrl = rst ? (ctrl_of(st, z) & ~RST_MASK) : ctrl_of(st, z);
        e.cnt  = exp_cnt;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (rst) exp_cnt = 0;
    endtask

    // seq packs up to five state codes, first state in the top nibble.
    task automatic instr(input logic [5:0] op, input logic z, input int n, input logic [19:0] seq);
        for (int i = 0; i < n; i++)
            step(1'b0, seq[19-4*i -: 4], op, z);
        exp_cnt = exp_cnt + 1;
    endtask

    initial begin
        reset  = 1'b1;
        Opcode = 6'b0;
        Zero   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        step(1'b1, 4'd0, 6'b000000, 1'b0);

        instr(6'b100011, 1'b0, 5, 20'h01234);              // LW
        // Reset landing in MEMRD: MemRead must be masked in that cycle
        step(1'b0, 4'd0, 6'b100011, 1'b0);
        step(1'b0, 4'd1, 6'b100011, 1'b0);
        step(1'b0, 4'd2, 6'b100011, 1'b0);
        step(1'b1, 4'd3, 6'b100011, 1'b0);
        step(1'b1, 4'd0, 6'b100011, 1'b0);

        instr(6'b000100, 1'b1, 3, 20'h01800);              // BEQ taken
        instr(6'b000100, 1'b0, 3, 20'h01800);              // BEQ not taken
        step(1'b1, 4'd0, 6'b000000, 1'b0);

        instr(6'b101011, 1'b0, 4, 20'h01250);              // SW
        instr(6'b000000, 1'b1, 4, 20'h01670);              // RTYPE
        instr(6'b001000, 1'b0, 4, 20'h01AB0);              // ADDI
        instr(6'b000010, 1'b0, 3, 20'h01900);              // J
        instr(6'b000100, 1'b1, 3, 20'h01800);
        instr(6'b000100, 1'b0, 3, 20'h01800);
        instr(6'b000010, 1'b1, 3, 20'h01900);
        instr(6'b000010, 1'b0, 3, 20'h01900);              // 8th retire: 3-bit count wraps to 0

        step(1'b0, 4'd0, 6'b111111, 1'b0);
        step(1'b0, 4'd1, 6'b111111, 1'b0);
        for (int i = 0; i < 11; i++)
            step(1'b0, 4'd15, 6'b111111, 1'b0);
        step(1'b1, 4'd15, 6'b111111, 1'b0);
        instr(6'b000010, 1'b0, 3, 20'h01900);
        step(1'b0, 4'd0, 6'b000000, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clock);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d records left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter CNT_W, default 32, SHALL set the width of the retired-instruction counter.
REQ-002 clock  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-004 Opcode  in  6  SHALL be the instruction-register opcode field [31:26], valid from DECODE onward.
REQ-005 Zero  in  1  SHALL be the ALU zero flag, sampled only in BRANCH.
REQ-006 RegDst, ALUSrc, MemWrite, MemRead, MemToReg, RegWrite  out  1 each  SHALL be the datapath controls of the same names.
REQ-007 ALUOp  out  2  SHALL encode 00 add, 01 subtract, 10 use FuncCode.
REQ-008 IRWrite  out  1  SHALL load the instruction register.
REQ-009 PCWrite  out  1  SHALL update the PC.
REQ-010 PCSrc  out  2  SHALL select the next PC: 00 PC+4, 01 branch target, 10 jump target.
REQ-011 Trap  out  1  SHALL flag an illegal opcode.
REQ-012 InstrCount  out  CNT_W  SHALL count retired instructions.
REQ-013 State  out  4  SHALL expose the current state encoding for debug.

Function
REQ-014 Opcodes SHALL be: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
REQ-015 States and encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, TRAP 15.
REQ-016 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR (LW/SW), EXEC (RTYPE), BRANCH (BEQ), IEXEC (ADDI), JUMP (J), TRAP (any other opcode); MEMADR->MEMRD (LW) or MEMWR (SW); MEMRD->MEMWB; EXEC->RWB; IEXEC->IWB; MEMWB, MEMWR, RWB, IWB, BRANCH, JUMP->FETCH; TRAP->TRAP.
REQ-017 Instruction latency SHALL be: LW 5 cycles, SW/RTYPE/ADDI 4 cycles, BEQ/J 3 cycles.
REQ-018 FETCH SHALL drive MemRead=1, IRWrite=1, PCWrite=1, PCSrc=00, ALUOp=00.
REQ-019 MEMADR and IEXEC SHALL drive ALUSrc=1, ALUOp=00; EXEC SHALL drive ALUSrc=0, ALUOp=10; BRANCH SHALL drive ALUSrc=0, ALUOp=01.
REQ-020 MEMRD SHALL drive MemRead=1; MEMWR SHALL drive MemWrite=1.
REQ-021 MEMWB SHALL drive RegWrite=1, MemToReg=1, RegDst=0; RWB SHALL drive RegWrite=1, MemToReg=0, RegDst=1; IWB SHALL drive RegWrite=1, MemToReg=0, RegDst=0.
REQ-022 BRANCH SHALL drive PCSrc=01 with PCWrite=Zero (the only Mealy output); JUMP SHALL drive PCSrc=10, PCWrite=1.
REQ-023 Every output not listed for a state SHALL be 0 in that state.
REQ-024 MemRead and MemWrite SHALL never be asserted in the same cycle.
REQ-025 InstrCount SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, IWB, BRANCH, or JUMP, and SHALL wrap from all-ones to 0.
REQ-026 TRAP SHALL hold Trap=1 with all strobes 0, and SHALL not increment InstrCount until reset.

Reset
REQ-027 On any rising edge with reset=1, the FSM SHALL enter FETCH and InstrCount SHALL become 0, regardless of current state, including mid-instruction and TRAP.
REQ-028 While reset=1, MemRead, MemWrite, RegWrite, IRWrite, PCWrite, and Trap SHALL be forced to 0 combinationally.
REQ-029 Following reset, the first FETCH cycle SHALL begin in the first cycle with reset=0.

Structure
REQ-030 Opcode constants, the state encodings, and the ALUOp and PCSrc codes SHALL reside in a shared package (mips_ctrl_pkg) that ALUControl also uses.
REQ-031 The block SHALL consist of one state register plus a combinational output decoder, with no sub-module.

Verification
REQ-032 Reset asserted in MEMRD, then released: SHALL see State=0, InstrCount=0, and no MemRead during reset.
REQ-033 Opcode 100011 (LW): SHALL see states 0,1,2,3,4,0, RegWrite=1 with MemToReg=1 in state 4 only, and InstrCount 0->1.
REQ-034 Opcode 000100 with Zero=1, then again with Zero=0: SHALL see PCWrite=1/PCSrc=01 in BRANCH the first time, PCWrite=0 the second time, and both retire.
REQ-035 Opcode 101011 (SW) followed by 000000 (RTYPE): SHALL see MemWrite only in state 5, then RegDst=1, RegWrite=1 in state 7, with InstrCount=2.
REQ-036 Opcode 111111: SHALL see DECODE->TRAP, Trap=1 held for 10 cycles, InstrCount unchanged, and a clean exit on reset.
REQ-037 InstrCount preloaded (forced) to 0xFFFFFFFF, then J retired: SHALL see InstrCount=0.
